ddr_host_arbiter: RTL and testbench
===================================

Name: ddr_host_arbiter

Overview:
- Multi-port host front end for the DDR controller; successor to the single-host request path.
- Per-port request FIFOs, round-robin arbitration onto the single controller command port, in-order read-data return to the issuing port.
- Mode-register updates (CL/AL/BL/CWL/RD_PRE/WR_PRE) applied only after full drain, then signalled with an mrs_update pulse.

Parameters:
NUM_PORTS, 4, number of host ports (2..8)
FIFO_DEPTH, 4, per-port request FIFO entries (power of 2)
ADDR_W, 32, logical address width
DATA_W, 64, data width
TAG_DEPTH, 8, max outstanding reads (power of 2)

Ports:
CK_t  in  1  clock, rising edge
reset_n  in  1  synchronous active-low reset
host_req  in  NUM_PORTS*3  per-port request code: 3'b000 NOP, 3'b001 WRITE, 3'b010 READ, others treated as NOP
host_addr  in  NUM_PORTS*ADDR_W  per-port logical address
host_wdata  in  NUM_PORTS*DATA_W  per-port write data
host_rdy  out  NUM_PORTS  port FIFO not full
host_rd_valid  out  NUM_PORTS  one-hot read return strobe
host_rd_data  out  DATA_W  read return data
ctrl_valid  out  1  command presented to controller
ctrl_req  out  3  command code (WRITE/READ)
ctrl_addr  out  ADDR_W  command address
ctrl_wdata  out  DATA_W  command write data
cmd_rdy  in  1  controller accepts command this cycle
ctrl_rd_valid  in  1  controller read data strobe
ctrl_rd_data  in  DATA_W  controller read data
cfg_update  in  1  pulse: latch new mode values
cfg_CL, cfg_AL, cfg_BL, cfg_CWL  in  3, 2, 3, 3  new mode values
cfg_RD_PRE, cfg_WR_PRE  in  1, 1  new preamble modes
CL, AL, BL, CWL, RD_PRE, WR_PRE  out  as cfg_*  active mode values
mrs_update  out  1  one-cycle pulse on applied update
rd_err  out  1  sticky: read data with no outstanding tag

Behaviour:
- Reset (reset_n low at posedge): all FIFOs, tag FIFO, RR pointer, pending flag cleared; all outputs 0; host_rdy all 1 on first cycle after release.
- Push: port i pushes at posedge when host_req[i] is WRITE/READ and host_rdy[i]=1; a request presented while full is not taken and must be held by the host.
- States: ISSUE, DRAIN, MRS.
- ISSUE: when ctrl_valid=0 or (ctrl_valid & cmd_rdy), load the output register from the next eligible port head.
  - Eligible: FIFO non-empty; for a READ head, the tag FIFO must also be not full.
  - Search order starts at the RR pointer; pointer becomes granted+1 mod NUM_PORTS.
  - READ grant pushes the port index to the tag FIFO on the same edge.
  - ctrl_* hold stable while ctrl_valid & !cmd_rdy.
  - Handover with no eligible port: ctrl_valid drops to 0.
- Pending update: cfg_update latches cfg_* into a shadow register and sets pending; next state DRAIN.
  - A second cfg_update while pending overwrites the shadow.
- DRAIN: no new grants; an in-flight ctrl_valid completes normally. Pushes still accepted.
  - Exit to MRS when ctrl_valid=0 and tag FIFO empty.
- MRS: one cycle; active mode outputs take the shadow; mrs_update=1 for exactly this cycle; pending cleared; return to ISSUE.
- Read return: ctrl_rd_valid pops the tag FIFO head t.
  - Next cycle: host_rd_valid[t]=1, host_rd_data=ctrl_rd_data (1-cycle latency).
  - Back-to-back strobes are supported.
  - ctrl_rd_valid with tag FIFO empty: data discarded, rd_err set until reset.
- Same edge: a pop and a push on the tag FIFO are both honoured, and a grant may be taken on that edge with the tag FIFO full. A FIFO push and pop on the same port are both honoured.
- host_rd_data is 0 when no strobe is active.

Optional Feature:
- Macro: RD_PRIORITY_EN.
- Defined: in ISSUE, eligible READ heads are searched first (RR order among them); WRITE heads are considered only if no READ head is eligible. The RR pointer still advances past the granted port.
- Undefined: pure round-robin, command type ignored.

Test Plan:
- Reset, then port 0 WRITE addr 0x10 data 0xAA, cmd_rdy=1 -> ctrl_valid with ctrl_req=001, ctrl_addr=0x10, ctrl_wdata=0xAA; host_rdy all 1.
- Ports 0-3 each push one READ in the same cycle, cmd_rdy=1 -> grants in order 0,1,2,3; ctrl_rd_valid data D0..D3 -> host_rd_valid one-hot 0001,0010,0100,1000 with matching data, each 1 cycle after its strobe.
- Port 2 pushes 5 WRITEs with cmd_rdy=0 -> host_rdy[2]=0 after 4; ctrl_addr holds the first address until cmd_rdy=1.
- 2 READs outstanding, cfg_update with CL=5 -> no new grants; CL stays old until both reads return; then mrs_update pulses once and CL=5.
- ctrl_rd_valid with nothing outstanding -> no host_rd_valid, rd_err=1 and held.
- RD_PRIORITY_EN defined, port 0 WRITE and port 1 READ both pending, pointer at 0 -> port 1 granted first.

Source files
------------

// File: rtl/ddr_host_arbiter.sv
// Multi-port DDR host front end: per-port request FIFOs, round-robin command issue,
// in-order read return and drained mode-register update. Optional macro RD_PRIORITY_EN.
module ddr_host_arbiter #(
    parameter int unsigned NUM_PORTS  = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned TAG_DEPTH  = 8
) (
    input  logic                        CK_t,
    input  logic                        reset_n,
    input  logic [NUM_PORTS*3-1:0]      host_req,
    input  logic [NUM_PORTS*ADDR_W-1:0] host_addr,
    input  logic [NUM_PORTS*DATA_W-1:0] host_wdata,
    output logic [NUM_PORTS-1:0]        host_rdy,
    output logic [NUM_PORTS-1:0]        host_rd_valid,
    output logic [DATA_W-1:0]           host_rd_data,
    output logic                        ctrl_valid,
    output logic [2:0]                  ctrl_req,
    output logic [ADDR_W-1:0]           ctrl_addr,
    output logic [DATA_W-1:0]           ctrl_wdata,
    input  logic                        cmd_rdy,
    input  logic                        ctrl_rd_valid,
    input  logic [DATA_W-1:0]           ctrl_rd_data,
    input  logic                        cfg_update,
    input  logic [2:0]                  cfg_CL,
    input  logic [1:0]                  cfg_AL,
    input  logic [2:0]                  cfg_BL,
    input  logic [2:0]                  cfg_CWL,
    input  logic                        cfg_RD_PRE,
    input  logic                        cfg_WR_PRE,
    output logic [2:0]                  CL,
    output logic [1:0]                  AL,
    output logic [2:0]                  BL,
    output logic [2:0]                  CWL,
    output logic                        RD_PRE,
    output logic                        WR_PRE,
    output logic                        mrs_update,
    output logic                        rd_err
);

    localparam int unsigned PW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned FW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CW  = FW + 1;
    localparam int unsigned TW  = $clog2(TAG_DEPTH);
    localparam int unsigned TCW = TW + 1;
    localparam logic [2:0] REQ_WRITE = 3'b001;
    localparam logic [2:0] REQ_READ  = 3'b010;

    typedef struct packed {
        logic              rd;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    typedef struct packed {
        logic [2:0] cl;
        logic [1:0] al;
        logic [2:0] bl;
        logic [2:0] cwl;
        logic       rd_pre;
        logic       wr_pre;
    } mode_t;

    typedef enum logic [1:0] {ST_ISSUE, ST_DRAIN, ST_MRS} state_t;

    req_t            r_fifo [NUM_PORTS][FIFO_DEPTH];
    logic [FW-1:0]   r_wp   [NUM_PORTS];
    logic [FW-1:0]   r_rp   [NUM_PORTS];
    logic [CW-1:0]   r_cnt  [NUM_PORTS];
    logic [PW-1:0]   r_tag_mem [TAG_DEPTH];
    logic [TW-1:0]   r_tag_wp, r_tag_rp;
    logic [TCW-1:0]  r_tag_cnt;
    logic [PW-1:0]   r_ptr;
    state_t          r_state, w_state_nxt;
    logic            r_pending, w_pend_nxt;
    mode_t           r_shadow, r_mode, w_cfg, w_shadow_nxt;
    logic            r_mrs_update, r_rd_err;
    logic            r_ctrl_valid;
    logic [2:0]      r_ctrl_req;
    logic [ADDR_W-1:0] r_ctrl_addr;
    logic [DATA_W-1:0] r_ctrl_wdata;
    logic [NUM_PORTS-1:0] r_host_rd_valid;
    logic [DATA_W-1:0]    r_host_rd_data;

    req_t                 w_in   [NUM_PORTS];
    req_t                 w_head [NUM_PORTS];
    req_t                 w_gh;
    logic [NUM_PORTS-1:0] w_rdy, w_push, w_pop, w_elig;
    logic                 w_tag_room, w_tag_pop, w_tag_push;
    logic                 w_load, w_take, w_apply;
    logic                 w_grant_vld;
    logic [PW-1:0]        w_grant_idx;

    function automatic logic [PW-1:0] f_wrap(input logic [PW-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NUM_PORTS) s = s - NUM_PORTS;
        return PW'(s);
    endfunction

    assign w_cfg      = {cfg_CL, cfg_AL, cfg_BL, cfg_CWL, cfg_RD_PRE, cfg_WR_PRE};
    // A pop on this edge frees a slot, so a full tag FIFO can still accept a READ grant.
    assign w_tag_room = (r_tag_cnt != TCW'(TAG_DEPTH)) || ctrl_rd_valid;
    assign w_tag_pop  = ctrl_rd_valid && (r_tag_cnt != '0);
    assign w_take     = w_load && w_grant_vld;
    assign w_gh       = w_head[w_grant_idx];
    assign w_tag_push = w_take && w_gh.rd;

    // Per-port head, readiness, push and eligibility.
    always_comb begin
        w_rdy  = '0;
        w_push = '0;
        w_elig = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            w_in[i].rd    = (host_req[i*3 +: 3] == REQ_READ);
            w_in[i].addr  = host_addr[i*ADDR_W +: ADDR_W];
            w_in[i].wdata = host_wdata[i*DATA_W +: DATA_W];
            w_head[i]     = r_fifo[i][r_rp[i]];
            w_rdy[i]      = (r_cnt[i] != CW'(FIFO_DEPTH));
            w_push[i]     = w_rdy[i] && ((host_req[i*3 +: 3] == REQ_WRITE) ||
                                         (host_req[i*3 +: 3] == REQ_READ));
            w_elig[i]     = (r_cnt[i] != '0) && (!w_head[i].rd || w_tag_room);
        end
    end

    // Round-robin search from the pointer.
    always_comb begin
        logic [PW-1:0] v_idx;
        v_idx       = r_ptr;
        w_grant_vld = 1'b0;
        w_grant_idx = r_ptr;
`ifdef RD_PRIORITY_EN
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            v_idx = f_wrap(r_ptr, k);
            if (!w_grant_vld && w_elig[v_idx] && w_head[v_idx].rd) begin
                w_grant_vld = 1'b1;
                w_grant_idx = v_idx;
            end
        end
`endif
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            v_idx = f_wrap(r_ptr, k);
            if (!w_grant_vld && w_elig[v_idx]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = v_idx;
            end
        end
    end

    always_comb begin
        w_pop = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            w_pop[i] = w_take && (w_grant_idx == PW'(i));
        end
    end

    always_ff @(posedge CK_t) begin
        if (!reset_n) r_state <= ST_ISSUE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_load       = 1'b0;
        w_apply      = 1'b0;
        w_pend_nxt   = r_pending;
        w_shadow_nxt = cfg_update ? w_cfg : r_shadow;
        case (r_state)
            ST_ISSUE: begin
                w_load = !cfg_update && (!r_ctrl_valid || cmd_rdy);
                if (cfg_update) begin
                    w_pend_nxt  = 1'b1;
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!r_ctrl_valid && (r_tag_cnt == '0)) begin
                    w_apply     = 1'b1;
                    w_state_nxt = ST_MRS;
                end
            end
            ST_MRS: begin
                if (cfg_update) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_pend_nxt  = 1'b0;
                    w_state_nxt = ST_ISSUE;
                end
            end
            default: w_state_nxt = ST_ISSUE;
        endcase
    end

    // Storage arrays carry no reset; pointers and counts define their contents.
    always_ff @(posedge CK_t) begin
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (w_push[i]) r_fifo[i][r_wp[i]] <= w_in[i];
        end
        if (w_tag_push) r_tag_mem[r_tag_wp] <= w_grant_idx;
    end

    always_ff @(posedge CK_t) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                r_wp[i]  <= '0;
                r_rp[i]  <= '0;
                r_cnt[i] <= '0;
            end
            r_tag_wp        <= '0;
            r_tag_rp        <= '0;
            r_tag_cnt       <= '0;
            r_ptr           <= '0;
            r_pending       <= 1'b0;
            r_shadow        <= '0;
            r_mode          <= '0;
            r_mrs_update    <= 1'b0;
            r_rd_err        <= 1'b0;
            r_ctrl_valid    <= 1'b0;
            r_ctrl_req      <= '0;
            r_ctrl_addr     <= '0;
            r_ctrl_wdata    <= '0;
            r_host_rd_valid <= '0;
            r_host_rd_data  <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                if (w_push[i]) r_wp[i] <= r_wp[i] + FW'(1);
                if (w_pop[i])  r_rp[i] <= r_rp[i] + FW'(1);
                r_cnt[i] <= r_cnt[i] + CW'(w_push[i]) - CW'(w_pop[i]);
            end

            if (w_load) begin
                if (w_grant_vld) begin
                    r_ctrl_valid <= 1'b1;
                    r_ctrl_req   <= w_gh.rd ? REQ_READ : REQ_WRITE;
                    r_ctrl_addr  <= w_gh.addr;
                    r_ctrl_wdata <= w_gh.wdata;
                    r_ptr        <= f_wrap(w_grant_idx, 1);
                end else begin
                    r_ctrl_valid <= 1'b0;
                end
            end else if (r_ctrl_valid && cmd_rdy) begin
                r_ctrl_valid <= 1'b0;
            end

            if (w_tag_push) r_tag_wp <= r_tag_wp + TW'(1);
            if (w_tag_pop)  r_tag_rp <= r_tag_rp + TW'(1);
            r_tag_cnt <= r_tag_cnt + TCW'(w_tag_push) - TCW'(w_tag_pop);

            r_host_rd_valid <= w_tag_pop ? (NUM_PORTS'(1) << r_tag_mem[r_tag_rp]) : '0;
            r_host_rd_data  <= w_tag_pop ? ctrl_rd_data : '0;
            r_rd_err        <= r_rd_err | (ctrl_rd_valid && (r_tag_cnt == '0));

            r_shadow     <= w_shadow_nxt;
            r_pending    <= w_pend_nxt;
            r_mrs_update <= w_apply;
            if (w_apply) r_mode <= w_shadow_nxt;
        end
    end

    assign host_rdy      = w_rdy;
    assign host_rd_valid = r_host_rd_valid;
    assign host_rd_data  = r_host_rd_data;
    assign ctrl_valid    = r_ctrl_valid;
    assign ctrl_req      = r_ctrl_req;
    assign ctrl_addr     = r_ctrl_addr;
    assign ctrl_wdata    = r_ctrl_wdata;
    assign CL            = r_mode.cl;
    assign AL            = r_mode.al;
    assign BL            = r_mode.bl;
    assign CWL           = r_mode.cwl;
    assign RD_PRE        = r_mode.rd_pre;
    assign WR_PRE        = r_mode.wr_pre;
    assign mrs_update    = r_mrs_update;
    assign rd_err        = r_rd_err;

endmodule

// File: tb/tb_ddr_host_arbiter.sv
// Bench for ddr_host_arbiter: queue-based reference model checked every cycle plus directed literals.
module tb_ddr_host_arbiter;

    localparam int NP = 4;
    localparam int FD = 4;
    localparam int TD = 8;

    logic          CK_t = 1'b0;
    logic          reset_n;
    logic [11:0]   host_req;
    logic [127:0]  host_addr;
    logic [255:0]  host_wdata;
    logic [3:0]    host_rdy, host_rd_valid;
    logic [63:0]   host_rd_data;
    logic          ctrl_valid;
    logic [2:0]    ctrl_req;
    logic [31:0]   ctrl_addr;
    logic [63:0]   ctrl_wdata;
    logic          cmd_rdy, ctrl_rd_valid;
    logic [63:0]   ctrl_rd_data;
    logic          cfg_update;
    logic [2:0]    cfg_CL, cfg_BL, cfg_CWL, CL, BL, CWL;
    logic [1:0]    cfg_AL, AL;
    logic          cfg_RD_PRE, cfg_WR_PRE, RD_PRE, WR_PRE;
    logic          mrs_update, rd_err;

    ddr_host_arbiter dut (
        .CK_t(CK_t), .reset_n(reset_n),
        .host_req(host_req), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rdy(host_rdy), .host_rd_valid(host_rd_valid), .host_rd_data(host_rd_data),
        .ctrl_valid(ctrl_valid), .ctrl_req(ctrl_req), .ctrl_addr(ctrl_addr), .ctrl_wdata(ctrl_wdata),
        .cmd_rdy(cmd_rdy), .ctrl_rd_valid(ctrl_rd_valid), .ctrl_rd_data(ctrl_rd_data),
        .cfg_update(cfg_update), .cfg_CL(cfg_CL), .cfg_AL(cfg_AL), .cfg_BL(cfg_BL), .cfg_CWL(cfg_CWL),
        .cfg_RD_PRE(cfg_RD_PRE), .cfg_WR_PRE(cfg_WR_PRE),
        .CL(CL), .AL(AL), .BL(BL), .CWL(CWL), .RD_PRE(RD_PRE), .WR_PRE(WR_PRE),
        .mrs_update(mrs_update), .rd_err(rd_err)
    );

    always #5 CK_t = ~CK_t;

    typedef struct {
        bit          rd;
        logic [31:0] addr;
        logic [63:0] data;
    } mreq_t;

    // Reference model state: plain queues, pointer as integer, phase 0 issue / 1 drain / 2 mrs.
    mreq_t       mq [NP][$];
    int          tq [$];
    int          m_ptr, m_phase;
    bit          m_err, e_valid, e_mrs;
    logic [2:0]  e_req;
    logic [31:0] e_addr;
    logic [63:0] e_wdata, e_rdd;
    logic [3:0]  e_rdv;
    logic [12:0] m_shadow, m_mode;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input bit room);
        int p;
`ifdef RD_PRIORITY_EN
        for (int k = 0; k < NP; k++) begin
            p = (m_ptr + k) % NP;
            if (mq[p].size() > 0 && mq[p][0].rd && room) return p;
        end
`endif
        for (int k = 0; k < NP; k++) begin
            p = (m_ptr + k) % NP;
            if (mq[p].size() > 0 && (!mq[p][0].rd || room)) return p;
        end
        return -1;
    endfunction

    task automatic model_step();
        bit          room, old_valid;
        int          old_tags, g, t;
        bit          rdy [NP];
        logic [2:0]  code;
        mreq_t       h, n;
        logic [12:0] cfg_vec;
        if (!reset_n) begin
            for (int p = 0; p < NP; p++) mq[p].delete();
            tq.delete();
            m_ptr = 0; m_phase = 0; m_err = 0; m_shadow = '0; m_mode = '0;
            e_valid = 0; e_req = '0; e_addr = '0; e_wdata = '0; e_rdv = '0; e_rdd = '0; e_mrs = 0;
            return;
        end
        cfg_vec = {cfg_CL, cfg_AL, cfg_BL, cfg_CWL, cfg_RD_PRE, cfg_WR_PRE};
        for (int p = 0; p < NP; p++) rdy[p] = (mq[p].size() < FD);
        room      = (tq.size() < TD) || ctrl_rd_valid;
        old_valid = e_valid;
        old_tags  = tq.size();
        e_rdv = '0;
        e_rdd = '0;
        if (ctrl_rd_valid) begin
            if (tq.size() > 0) begin
                t     = tq.pop_front();
                e_rdv = 4'(1 << t);
                e_rdd = ctrl_rd_data;
            end else begin
                m_err = 1;
            end
        end
        if (m_phase == 0 && !cfg_update && (!old_valid || cmd_rdy)) begin
            g = pick(room);
            if (g >= 0) begin
                h       = mq[g].pop_front();
                e_valid = 1;
                e_req   = h.rd ? 3'b010 : 3'b001;
                e_addr  = h.addr;
                e_wdata = h.data;
                m_ptr   = (g + 1) % NP;
                if (h.rd) tq.push_back(g);
            end else begin
                e_valid = 0;
            end
        end else if (old_valid && cmd_rdy) begin
            e_valid = 0;
        end
        for (int p = 0; p < NP; p++) begin
            code = host_req[p*3 +: 3];
            if (rdy[p] && (code == 3'd1 || code == 3'd2)) begin
                n.rd   = (code == 3'd2);
                n.addr = host_addr[p*32 +: 32];
                n.data = host_wdata[p*64 +: 64];
                mq[p].push_back(n);
            end
        end
        e_mrs = 0;
        case (m_phase)
            0: if (cfg_update) begin m_shadow = cfg_vec; m_phase = 1; end
            1: begin
                if (cfg_update) m_shadow = cfg_vec;
                if (!old_valid && old_tags == 0) begin m_mode = m_shadow; e_mrs = 1; m_phase = 2; end
            end
            default: begin
                if (cfg_update) begin m_shadow = cfg_vec; m_phase = 1; end
                else m_phase = 0;
            end
        endcase
    endtask

    task automatic compare_all();
        logic [3:0] exp_rdy;
        for (int p = 0; p < NP; p++) exp_rdy[p] = (mq[p].size() < FD);
        check("host_rdy", 64'(host_rdy), 64'(exp_rdy));
        check("ctrl_valid", 64'(ctrl_valid), 64'(e_valid));
        if (e_valid) begin
            check("ctrl_req", 64'(ctrl_req), 64'(e_req));
            check("ctrl_addr", 64'(ctrl_addr), 64'(e_addr));
            check("ctrl_wdata", ctrl_wdata, e_wdata);
        end
        check("host_rd_valid", 64'(host_rd_valid), 64'(e_rdv));
        check("host_rd_data", host_rd_data, e_rdd);
        check("mrs_update", 64'(mrs_update), 64'(e_mrs));
        check("mode", 64'({CL, AL, BL, CWL, RD_PRE, WR_PRE}), 64'(m_mode));
        check("rd_err", 64'(rd_err), 64'(m_err));
    endtask

    task automatic cycle();
        @(posedge CK_t);
        model_step();
        @(negedge CK_t);
        compare_all();
    endtask

    task automatic clear_inputs();
        host_req = '0; host_addr = '0; host_wdata = '0;
        cmd_rdy = 0; ctrl_rd_valid = 0; ctrl_rd_data = '0;
        cfg_update = 0; cfg_CL = '0; cfg_AL = '0; cfg_BL = '0; cfg_CWL = '0;
        cfg_RD_PRE = 0; cfg_WR_PRE = 0;
    endtask

    task automatic set_req(input int p, input logic [2:0] code, input logic [31:0] a, input logic [63:0] d);
        host_req[p*3 +: 3]    = code;
        host_addr[p*32 +: 32] = a;
        host_wdata[p*64 +: 64] = d;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_n = 0;
        cycle();
        reset_n = 1;
    endtask

    initial begin
        int  pulses;
        bit  take;
        clear_inputs();
        reset_n = 0;
        repeat (2) cycle();
        reset_n = 1;
        check("rst_rdy", 64'(host_rdy), 64'hF);
        check("rst_valid", 64'(ctrl_valid), 64'h0);
        check("rst_rderr", 64'(rd_err), 64'h0);

        // Single write on port 0.
        cmd_rdy = 1;
        set_req(0, 3'b001, 32'h10, 64'hAA);
        cycle();
        host_req = '0;
        cycle();
        check("w1_valid", 64'(ctrl_valid), 64'h1);
        check("w1_req", 64'(ctrl_req), 64'h1);
        check("w1_addr", 64'(ctrl_addr), 64'h10);
        check("w1_wdata", ctrl_wdata, 64'hAA);
        check("w1_rdy", 64'(host_rdy), 64'hF);
        cycle();
        check("w1_drop", 64'(ctrl_valid), 64'h0);

        // Four simultaneous reads, in-order return.
        do_reset();
        cmd_rdy = 1;
        for (int p = 0; p < NP; p++) set_req(p, 3'b010, 32'h100 + 32'(p), 64'h0);
        cycle();
        host_req = '0;
        for (int g = 0; g < NP; g++) begin
            cycle();
            check("rr_addr", 64'(ctrl_addr), 64'h100 + 64'(g));
            check("rr_req", 64'(ctrl_req), 64'h2);
        end
        cycle();
        for (int k = 0; k < NP; k++) begin
            ctrl_rd_valid = 1;
            ctrl_rd_data  = 64'hD0 + 64'(k);
            cycle();
            check("ret_onehot", 64'(host_rd_valid), 64'(1) << k);
            check("ret_data", host_rd_data, 64'hD0 + 64'(k));
        end
        ctrl_rd_valid = 0;
        cycle();
        check("ret_idle", 64'(host_rd_valid), 64'h0);
        check("ret_idle_data", host_rd_data, 64'h0);

        // Port 2 backpressure with the controller stalled.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            set_req(2, 3'b001, 32'h200 + 32'(k), 64'h2000 + 64'(k));
            cycle();
        end
        check("bp_rdy", 64'(host_rdy), 64'hB);
        check("bp_hold_addr", 64'(ctrl_addr), 64'h200);
        set_req(2, 3'b001, 32'h205, 64'h2005);
        repeat (3) begin
            cycle();
            check("bp_stall_addr", 64'(ctrl_addr), 64'h200);
            check("bp_stall_rdy", 64'(host_rdy[2]), 64'h0);
        end
        cmd_rdy = 1;
        cycle();
        check("bp_next_addr", 64'(ctrl_addr), 64'h201);
        for (int n = 0; n < 10; n++) begin
            take = host_rdy[2];
            cycle();
            if (take) break;
        end
        host_req = '0;
        repeat (8) cycle();

        // Mode update waits for two outstanding reads.
        do_reset();
        cmd_rdy = 1;
        set_req(0, 3'b010, 32'h300, 64'h0);
        set_req(1, 3'b010, 32'h301, 64'h0);
        cycle();
        host_req = '0;
        repeat (3) cycle();
        set_req(3, 3'b001, 32'h303, 64'h33);
        cfg_update = 1;
        cfg_CL = 3'd5;
        cycle();
        host_req = '0;
        cfg_update = 0;
        repeat (4) begin
            cycle();
            check("drain_nogrant", 64'(ctrl_valid), 64'h0);
            check("drain_cl_old", 64'(CL), 64'h0);
        end
        for (int k = 0; k < 2; k++) begin
            ctrl_rd_valid = 1;
            ctrl_rd_data  = 64'hE0 + 64'(k);
            cycle();
            check("drain_cl_hold", 64'(CL), 64'h0);
        end
        ctrl_rd_valid = 0;
        pulses = 0;
        for (int n = 0; n < 6; n++) begin
            cycle();
            if (mrs_update) pulses++;
        end
        check("mrs_pulses", 64'(pulses), 64'h1);
        check("mrs_cl_new", 64'(CL), 64'h5);

        // Read data with nothing outstanding.
        do_reset();
        ctrl_rd_valid = 1;
        ctrl_rd_data  = 64'h55;
        cycle();
        ctrl_rd_valid = 0;
        check("err_no_strobe", 64'(host_rd_valid), 64'h0);
        check("err_set", 64'(rd_err), 64'h1);
        repeat (3) cycle();
        check("err_sticky", 64'(rd_err), 64'h1);

        // Write on port 0 and read on port 1 contend with the pointer at 0.
        do_reset();
        set_req(0, 3'b001, 32'h400, 64'h44);
        set_req(1, 3'b010, 32'h401, 64'h0);
        cycle();
        host_req = '0;
        cycle();
`ifdef RD_PRIORITY_EN
        check("prio_first", 64'(ctrl_addr), 64'h401);
        check("prio_req", 64'(ctrl_req), 64'h2);
`else
        check("rr_first", 64'(ctrl_addr), 64'h400);
        check("rr_req1", 64'(ctrl_req), 64'h1);
`endif
        cmd_rdy = 1;
        cycle();
`ifdef RD_PRIORITY_EN
        check("prio_second", 64'(ctrl_addr), 64'h400);
`else
        check("rr_second", 64'(ctrl_addr), 64'h401);
`endif
        repeat (3) cycle();

        // Fill the tag FIFO, then grant on the same edge as a pop.
        do_reset();
        cmd_rdy = 1;
        for (int n = 0; n < 30; n++) begin
            for (int p = 0; p < NP; p++) set_req(p, 3'b010, 32'h500 + 32'(n*4 + p), 64'h0);
            cycle();
        end
        check("tagfull_stall", 64'(ctrl_valid), 64'h0);
        ctrl_rd_valid = 1;
        ctrl_rd_data  = 64'hF00D;
        cycle();
        check("tagfull_grant", 64'(ctrl_valid), 64'h1);

        // Mixed traffic.
        for (int n = 0; n < 150; n++) begin
            for (int p = 0; p < NP; p++)
                set_req(p, 3'($urandom_range(0, 4)), $urandom, {$urandom, $urandom});
            cmd_rdy       = ($urandom_range(0, 3) != 0);
            ctrl_rd_valid = ($urandom_range(0, 2) == 0);
            ctrl_rd_data  = {$urandom, $urandom};
            cfg_update    = ($urandom_range(0, 24) == 0);
            cfg_CL  = 3'($urandom); cfg_AL = 2'($urandom); cfg_BL = 3'($urandom);
            cfg_CWL = 3'($urandom); cfg_RD_PRE = 1'($urandom); cfg_WR_PRE = 1'($urandom);
            cycle();
        end
        clear_inputs();
        cmd_rdy = 1;
        ctrl_rd_valid = 1;
        repeat (20) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
